// File: rtl/baser_257b_transcoder_if.sv
// Stream interface between the 66b block generator and the 256b/257b
// transcoder. The master drives 66b blocks in; the slave (the transcoder)
// drives the 257b transcoded block and its one-cycle valid strobe out.
interface baser_257b_transcoder_if #(
  parameter int FRAME_WIDTH = 66,
  parameter int TC_WIDTH    = 257
);

  logic                   i_valid;
  logic                   i_align;
  logic [FRAME_WIDTH-1:0] i_tx_coded;
  logic [TC_WIDTH-1:0]    o_tx_xcoded;
  logic                   o_valid;

  modport master (
    output i_valid,
    output i_align,
    output i_tx_coded,
    input  o_tx_xcoded,
    input  o_valid
  );

  modport slave (
    input  i_valid,
    input  i_align,
    input  i_tx_coded,
    output o_tx_xcoded,
    output o_valid
  );

endinterface

// File: rtl/baser_257b_transcoder.sv
// baser_257b_transcoder
// Transmit-side 256b/257b transcoder. Collects four consecutive 66b blocks
// and emits one 257b block using the compressed first-control-block format.
// Blocks with a bad sync header or an unknown control type are replaced by
// an error control block (type 0x1E, eight 7'h1E characters) before packing.
// Optional statistics counters are built only when BASER_TC_COUNTERS_EN is
// defined; otherwise all counter outputs are tied to zero.
module baser_257b_transcoder #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH,
  parameter int TC_DATA_WIDTH = 4 * DATA_WIDTH,
  parameter int TC_HDR_WIDTH  = 1,
  parameter int TC_WIDTH      = TC_DATA_WIDTH + TC_HDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  baser_257b_transcoder_if.slave         tc,
  output logic [31:0]                    o_block_count,
  output logic [31:0]                    o_data_count,
  output logic [31:0]                    o_ctrl_count,
  output logic [31:0]                    o_inv_sh_count,
  output logic [31:0]                    o_inv_type_count
);

  localparam logic [HDR_WIDTH-1:0]  SH_DATA     = 2'b01;
  localparam logic [HDR_WIDTH-1:0]  SH_CTRL     = 2'b10;
  localparam logic [DATA_WIDTH-1:0] ERR_PAYLOAD = {{8{7'h1E}}, 8'h1E};

  logic [HDR_WIDTH-1:0]  in_sh;
  logic [7:0]            in_type;
  logic                  type_legal;
  logic                  inv_sh;
  logic                  inv_type;
  logic                  cur_is_data;
  logic [DATA_WIDTH-1:0] cur_payload;

  logic [1:0]            idx;
  logic [DATA_WIDTH-1:0] slot_payload [3];
  logic [2:0]            slot_data;

  logic [DATA_WIDTH-1:0] grp_payload [4];
  logic [3:0]            grp_data;
  logic                  all_data;
  logic                  emit;
  logic [TC_WIDTH-1:0]   tc_word;

  // Classify the incoming block and substitute the error block when needed
  always_comb begin
    in_sh   = tc.i_tx_coded[HDR_WIDTH-1:0];
    in_type = tc.i_tx_coded[HDR_WIDTH+7:HDR_WIDTH];
    case (in_type)
      8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: type_legal = 1'b1;
      default:                                          type_legal = 1'b0;
    endcase
    inv_sh   = (in_sh != SH_DATA) && (in_sh != SH_CTRL);
    inv_type = (in_sh == SH_CTRL) && !type_legal;
    if (inv_sh || inv_type) begin
      cur_is_data = 1'b0;
      cur_payload = ERR_PAYLOAD;
    end else begin
      cur_is_data = (in_sh == SH_DATA);
      cur_payload = tc.i_tx_coded[FRAME_WIDTH-1:HDR_WIDTH];
    end
  end

  // Assemble the candidate group: three stored slots plus the live block
  always_comb begin
    grp_payload[0] = slot_payload[0];
    grp_payload[1] = slot_payload[1];
    grp_payload[2] = slot_payload[2];
    grp_payload[3] = cur_payload;
    grp_data       = {cur_is_data, slot_data};
    all_data       = &grp_data;
    emit           = tc.i_valid && !tc.i_align && (idx == 2'd3);
  end

  // Pack the group; the first control block loses its type high nibble
  always_comb begin
    tc_word = '0;
    if (all_data) begin
      tc_word = {grp_payload[3], grp_payload[2], grp_payload[1], grp_payload[0],
                 {TC_HDR_WIDTH{1'b1}}};
    end else if (!grp_data[0]) begin
      tc_word = {grp_payload[3], grp_payload[2], grp_payload[1],
                 grp_payload[0][63:8], grp_payload[0][3:0],
                 grp_data, 1'b0};
    end else if (!grp_data[1]) begin
      tc_word = {grp_payload[3], grp_payload[2],
                 grp_payload[1][63:8], grp_payload[1][3:0],
                 grp_payload[0], grp_data, 1'b0};
    end else if (!grp_data[2]) begin
      tc_word = {grp_payload[3],
                 grp_payload[2][63:8], grp_payload[2][3:0],
                 grp_payload[1], grp_payload[0], grp_data, 1'b0};
    end else begin
      tc_word = {grp_payload[3][63:8], grp_payload[3][3:0],
                 grp_payload[2], grp_payload[1], grp_payload[0],
                 grp_data, 1'b0};
    end
  end

  // Slot index, slot storage and the registered transcoded output
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx            <= 2'd0;
      slot_data      <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        slot_payload[k] <= '0;
      end
      tc.o_tx_xcoded <= '0;
      tc.o_valid     <= 1'b0;
    end else begin
      tc.o_valid <= emit;
      if (emit) begin
        tc.o_tx_xcoded <= tc_word;
      end
      if (tc.i_align) begin
        if (tc.i_valid) begin
          slot_payload[0] <= cur_payload;
          slot_data[0]    <= cur_is_data;
          idx             <= 2'd1;
        end else begin
          idx <= 2'd0;
        end
      end else if (tc.i_valid) begin
        case (idx)
          2'd0: begin
            slot_payload[0] <= cur_payload;
            slot_data[0]    <= cur_is_data;
          end
          2'd1: begin
            slot_payload[1] <= cur_payload;
            slot_data[1]    <= cur_is_data;
          end
          2'd2: begin
            slot_payload[2] <= cur_payload;
            slot_data[2]    <= cur_is_data;
          end
          default: begin
          end
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

`ifdef BASER_TC_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Saturating statistics counters for groups and replaced blocks
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_block_count    <= 32'h0;
      o_data_count     <= 32'h0;
      o_ctrl_count     <= 32'h0;
      o_inv_sh_count   <= 32'h0;
      o_inv_type_count <= 32'h0;
    end else begin
      if (emit) begin
        o_block_count <= sat_inc(o_block_count);
        if (all_data) begin
          o_data_count <= sat_inc(o_data_count);
        end else begin
          o_ctrl_count <= sat_inc(o_ctrl_count);
        end
      end
      if (tc.i_valid && inv_sh) begin
        o_inv_sh_count <= sat_inc(o_inv_sh_count);
      end
      if (tc.i_valid && inv_type) begin
        o_inv_type_count <= sat_inc(o_inv_type_count);
      end
    end
  end
`else
  assign o_block_count    = 32'h0;
  assign o_data_count     = 32'h0;
  assign o_ctrl_count     = 32'h0;
  assign o_inv_sh_count   = 32'h0;
  assign o_inv_type_count = 32'h0;
`endif

endmodule

// File: doc/baser_257b_transcoder.md
# baser_257b_transcoder

Transmit-side 256b/257b transcoder for the BASE-R verification agents. It accepts a stream of 66b blocks, one per valid cycle, and groups each four consecutive blocks into one 257b transcoded block with the compressed first-control-block format. It emits that block with a one-cycle valid strobe. It sits between the 66b generator and the channel and is the counterpart of the 257b-to-66b checker.

## Interface
Parameters (the block is only defined for the default values):
- DATA_WIDTH, 64, 66b block payload width
- HDR_WIDTH, 2, sync header width
- FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH, 66b block width
- TC_DATA_WIDTH, 4*DATA_WIDTH, transcoded payload width (256)
- TC_HDR_WIDTH, 1, transcoded header width
- TC_WIDTH, TC_DATA_WIDTH+TC_HDR_WIDTH, transcoded block width (257)

Ports:
- clk  input  1  clock; all logic is rising-edge
- i_rst_n  input  1  reset, asynchronous and active-low
- i_valid  input  1  i_tx_coded carries a block this cycle
- i_align  input  1  restart grouping; the current i_valid block becomes block 0
- i_tx_coded  input  FRAME_WIDTH  66b block; [1:0] sync header, [65:2] payload, [9:2] block type
- o_tx_xcoded  output  TC_WIDTH  257b transcoded block
- o_valid  output  1  one-cycle strobe; o_tx_xcoded is new
- o_block_count  output  32  257b blocks emitted
- o_data_count  output  32  all-data 257b blocks emitted
- o_ctrl_count  output  32  257b blocks with at least one control block
- o_inv_sh_count  output  32  66b blocks with an invalid sync header
- o_inv_type_count  output  32  control 66b blocks with an unknown block type

## Operation
- Sync header 2'b01 means data and 2'b10 means control. 2'b00 and 2'b11 are invalid.
- The legal control block types are 0x1E, 0x2D, 0x33, 0x66, 0x55, 0x78, 0x4B, 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1 and 0xFF.
- Error replacement: a block with an invalid sync header, or a control block with an illegal type, is replaced before packing by an error control block. The error block has sync header 2'b10, type 0x1E and eight 7'h1E characters. The matching counter increments by 1. An invalid sync header takes precedence, so only o_inv_sh_count increments for that block.
- Grouping: a 2-bit index counts accepted blocks 0..3 and wraps after 3. Each accepted block is stored into slot[idx]. Cycles with i_valid=0 are ignored and leave the index unchanged.
- i_align=1 sets idx to 0 and discards any partial group.
  - If i_valid=1 in the same cycle, that block is stored as slot 0 and idx becomes 1.
  - If i_valid=0, idx becomes 0.
- Packing, applied when slot 3 is accepted:
  - All four blocks are data: bit[0]=1 and [256:1] = {p3,p2,p1,p0}, where pk is the 64b payload.
  - Otherwise: bit[0]=0 and bits[4:1] = per-block flags, where bit k+1 is 1 if block k is data.
  - Payloads follow from bit 5 in order 0..3.
  - Data blocks contribute 64 bits each.
  - The first (lowest-index) control block contributes 60 bits: {payload[63:8], type[3:0]}. The high nibble of the type is dropped.
  - Later control blocks contribute their full 64 bits.
  - Resulting start bit of block k: 5+64k up to and including the first control block, 1+64k after it.
- Each emitted block increments o_block_count. It also increments exactly one of o_data_count or o_ctrl_count.
- All counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values: o_tx_xcoded = 0, o_valid = 0, idx = 0, stored slots = 0, all counters = 0.
- Latency: when slot 3 is accepted at edge N, o_tx_xcoded and o_valid=1 are registered at edge N. o_valid is high for exactly one cycle. Between strobes, o_tx_xcoded holds its last value.
- The error counters update at the same edge the offending block is accepted.
- The group counters update at the same edge as o_valid.
- Maximum throughput is one 66b block per clk, which gives one 257b block every 4 cycles. There is no backpressure.
- i_align on the cycle slot 3 would have been accepted: no emission, the block becomes slot 0, and o_valid stays 0.
- Reset asserted mid-group: everything clears immediately and asynchronously, and the partial group is lost. After reset release, the first accepted block is slot 0.

## Configuration
- BASER_TC_COUNTERS_EN defined: all five counters are implemented as described.
- BASER_TC_COUNTERS_EN undefined: all counter outputs are tied to 32'h0 and no counter flops exist. Error replacement and packing are unchanged.

## Test plan
- Four data blocks, all payloads 64'hAAAA_AAAA_AAAA_AAAA -> o_tx_xcoded = {{32{8'hAA}},1'b1}, o_valid high 1 cycle, o_data_count = 1.
- Blocks C0 (type 0x78, 7×8'hAA), D1, D2, D3 all 8'hAA -> bit0 = 0, [4:1] = 4'b1110, [8:5] = 4'h8, [64:9] = 7×8'hAA, o_ctrl_count = 1.
- Blocks D0, C1 (0xFF), D2, C3 (0x87, 7'h0 then 7×7'h1E) -> [4:1] = 4'b0101, [72:69] = 4'hF, [200:193] = 8'h87.
- Block 1 with sync header 2'b11, then block 3 with type 0x86 -> o_inv_sh_count = 1, o_inv_type_count = 1, both slots packed as error type 0x1E blocks.
- Two data blocks, then i_align with i_valid, then 3 more data blocks -> exactly one o_valid, 3 cycles after the align cycle; the first two blocks are discarded.
- i_rst_n pulsed low after 2 blocks -> all outputs 0 at once; the next 4 blocks produce one o_valid with o_block_count = 1.
